mem_unaligned_ctrl: RTL and testbench

Parametrised, handshaked successor to the 16-bit-granular memory port: a single-port on-chip data memory controller that serves byte, half-word and word reads and writes at any byte address, including accesses straddling two RAM words. Unaligned writes use an internal read-modify-write sequence. Sits between the CPU load/store unit and a synchronous-read block RAM, and replaces the free-running clock-divider phase scheme with an explicit req/ready/done handshake.

---
 rtl/mem_pkg.sv | 37 +++
 rtl/sp_ram.sv | 33 +++
 rtl/mem_unaligned_ctrl.sv | 169 ++++++++++++++++
 tb/tb_mem_unaligned_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared size encodings, controller state type and lane masks
//               for the unaligned memory controller.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    localparam int SZ_B = 0;
    localparam int SZ_H = 1;
    localparam int SZ_W = 2;

    // Widest mask the helper builds; covers the double-word window up to DATA_W=128
    localparam int MASK_W = 256;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_A0   = 3'd1,
        ST_A1   = 3'd2,
        ST_CAP  = 3'd3,
        ST_WR0  = 3'd4,
        ST_WR1  = 3'd5,
        ST_DONE = 3'd6
    } state_t;

    function automatic logic [MASK_W-1:0] lane_mask(input int nbytes);
        lane_mask = '0;
        for (int i = 0; i < MASK_W / 8; i++) begin
            if (i < nbytes) begin
                lane_mask[8*i +: 8] = 8'hFF;
            end
        end
    endfunction

endpackage
`default_nettype wire

// File: rtl/sp_ram.sv
`default_nettype none
// ============================================================================
// Module      : sp_ram
// Description : Single-port RAM, one-cycle synchronous read, single write
//               enable; written in block-RAM inference form.
// Revision    : 1.0 - initial release
// ============================================================================
module sp_ram #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int AW     = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [AW-1:0]     i_addr,
    input  logic [DATA_W-1:0] i_wdata,
    output logic [DATA_W-1:0] o_rdata
);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [DATA_W-1:0] r_q;

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_addr] <= i_wdata;
        end
        r_q <= r_mem[i_addr];
    end

    assign o_rdata = r_q;

endmodule
`default_nettype wire

// File: rtl/mem_unaligned_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_unaligned_ctrl
// Description : Byte/half/word controller for a sync-read RAM supporting any
//               byte alignment, with read-modify-write for partial writes.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_unaligned_ctrl #(
    parameter  int DATA_W = 32,
    parameter  int DEPTH  = 1024,
    localparam int BYTES  = DATA_W / 8,
    localparam int ADDR_W = $clog2(DEPTH * BYTES),
    localparam int SZ_W   = ($clog2($clog2(BYTES) + 1) > 1) ? $clog2($clog2(BYTES) + 1) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req,
    input  logic              we,
    input  logic [SZ_W-1:0]   size,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              ready,
    output logic              done,
    output logic [DATA_W-1:0] rdata
);

    import mem_pkg::*;

    localparam int LOG2B = $clog2(BYTES);
    localparam int OFF_W = (LOG2B > 1) ? LOG2B : 1;
    localparam int NB_W  = LOG2B + 1;
    localparam int WA_W  = $clog2(DEPTH);
    localparam int W2    = 2 * DATA_W;
    localparam int SH_W  = $clog2(W2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_we;
    logic               r_span;
    logic [OFF_W-1:0]   r_off;
    logic [NB_W-1:0]    r_nb;
    logic [WA_W-1:0]    r_w0;
    logic [DATA_W-1:0]  r_wdata;
    logic [DATA_W-1:0]  r_lo;
    logic [DATA_W-1:0]  r_hi;
    logic [DATA_W-1:0]  r_rdata;

    logic [OFF_W-1:0]   w_off;
    logic [NB_W-1:0]    w_nb;
    logic [WA_W-1:0]    w_w0;
    logic [WA_W-1:0]    w_w1;
    logic               w_span;
    logic               w_aligned_full;
    logic [SH_W-1:0]    w_sh;
    logic [W2-1:0]      w_mask2;
    logic [W2-1:0]      w_wsh;
    logic [W2-1:0]      w_merged;
    logic [DATA_W-1:0]  w_extract;
    logic [DATA_W-1:0]  w_ram_q;
    logic               w_ram_we;
    logic [WA_W-1:0]    w_ram_addr;
    logic [DATA_W-1:0]  w_ram_wdata;

    // Request decode, used only on the accept edge
    assign w_off          = OFF_W'(addr & ADDR_W'(BYTES - 1));
    assign w_w0           = WA_W'(addr >> LOG2B);
    assign w_nb           = (int'(size) > LOG2B) ? NB_W'(BYTES) : (NB_W'(1) << size);
    assign w_span         = (int'(w_off) + int'(w_nb)) > BYTES;
    assign w_aligned_full = (int'(w_off) == 0) && (int'(w_nb) == BYTES);

    // Second word wraps to word 0 at the top of memory
    assign w_w1 = r_w0 + WA_W'(1);

    // Two-word window {hi,lo}: accessed bytes sit at lane offset r_off
    assign w_sh      = SH_W'(r_off) << 3;
    assign w_mask2   = W2'(lane_mask(int'(r_nb))) << w_sh;
    assign w_wsh     = {{DATA_W{1'b0}}, r_wdata} << w_sh;
    assign w_merged  = ({r_hi, r_lo} & ~w_mask2) | (w_wsh & w_mask2);
    assign w_extract = DATA_W'({w_ram_q, r_lo} >> w_sh) & DATA_W'(lane_mask(int'(r_nb)));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_ram_we    = 1'b0;
        w_ram_addr  = r_w0;
        w_ram_wdata = w_merged[DATA_W-1:0];
        case (r_state)
            ST_IDLE: begin
                if (req) begin
                    w_state_nxt = (we && w_aligned_full) ? ST_WR0 : ST_A0;
                end
            end
            ST_A0:   w_state_nxt = ST_A1;
            ST_A1: begin
                w_ram_addr  = w_w1;
                w_state_nxt = ST_CAP;
            end
            ST_CAP:  w_state_nxt = r_we ? ST_WR0 : ST_DONE;
            ST_WR0: begin
                w_ram_we    = 1'b1;
                w_state_nxt = r_span ? ST_WR1 : ST_DONE;
            end
            ST_WR1: begin
                w_ram_we    = 1'b1;
                w_ram_addr  = w_w1;
                w_ram_wdata = w_merged[W2-1:DATA_W];
                w_state_nxt = ST_DONE;
            end
            ST_DONE: w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_we    <= 1'b0;
            r_span  <= 1'b0;
            r_off   <= '0;
            r_nb    <= '0;
            r_w0    <= '0;
            r_wdata <= '0;
            r_lo    <= '0;
            r_hi    <= '0;
            r_rdata <= '0;
        end else begin
            if (r_state == ST_IDLE && req) begin
                r_we    <= we;
                r_span  <= w_span;
                r_off   <= w_off;
                r_nb    <= w_nb;
                r_w0    <= w_w0;
                r_wdata <= wdata;
            end
            if (r_state == ST_A1) begin
                r_lo <= w_ram_q;
            end
            if (r_state == ST_CAP) begin
                r_hi <= w_ram_q;
                if (!r_we) begin
                    r_rdata <= w_extract;
                end
            end
        end
    end

    sp_ram #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_ram_we),
        .i_addr  (w_ram_addr),
        .i_wdata (w_ram_wdata),
        .o_rdata (w_ram_q)
    );

    assign ready = (r_state == ST_IDLE);
    assign done  = (r_state == ST_DONE);
    assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_unaligned_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_unaligned_ctrl
// Description : Directed scoreboard bench for mem_unaligned_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_unaligned_ctrl;

    logic        clk   = 1'b0;
    logic        rst   = 1'b1;
    logic        req   = 1'b0;
    logic        we    = 1'b0;
    logic [1:0]  size  = 2'd0;
    logic [11:0] addr  = 12'd0;
    logic [31:0] wdata = 32'd0;
    logic        ready;
    logic        done;
    logic [31:0] rdata;

    mem_unaligned_ctrl #(
        .DATA_W (32),
        .DEPTH  (1024)
    ) dut (
        .clk   (clk),
        .rst   (rst),
        .req   (req),
        .we    (we),
        .size  (size),
        .addr  (addr),
        .wdata (wdata),
        .ready (ready),
        .done  (done),
        .rdata (rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        bit          rd;
        logic [31:0] exp;
        int          due;
    } exp_t;

    exp_t sb[$];
    int   checks    = 0;
    int   failures  = 0;
    int   ndone     = 0;
    int   exp_dones = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation
    always @(negedge clk) begin
        exp_t e;
        if (!rst && done) begin
            ndone++;
            if (sb.size() == 0) begin
                check("unexpected_done", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("done_cycle", cyc, e.due);
                if (e.rd) check("rdata", rdata, e.exp);
            end
        end
    end

    // lat = expected done cycle after accept; 0 means issue only and return
    task automatic do_acc(input string name, input bit iwe, input logic [1:0] isz,
                          input logic [11:0] ia, input logic [31:0] iwd,
                          input int lat, input logic [31:0] ex, input bit hold);
        int   n;
        exp_t e;
        n = 0;
        @(negedge clk);
        while (!ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!ready) begin
            check({name, "_ready_timeout"}, 32'd0, 32'd1);
            return;
        end
        req = 1'b1; we = iwe; size = isz; addr = ia; wdata = iwd;
        @(posedge clk);
        #1;
        if (!hold) req = 1'b0;
        if (lat == 0) return;
        e.rd  = !iwe;
        e.exp = ex;
        e.due = cyc + lat - 1;
        sb.push_back(e);
        exp_dones++;
        n = 0;
        @(negedge clk);
        while (!done && n < 20) begin
            check({name, "_busy_ready"}, {31'd0, ready}, 32'd0);
            @(negedge clk);
            n++;
        end
        if (!done) check({name, "_done_timeout"}, 32'd0, 32'd1);
        req = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", {31'd0, ready}, 32'd1);
        check("rst_done",  {31'd0, done},  32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;

        // Aligned word write and read
        do_acc("wr_al",   1, 2'd2, 12'h010, 32'hDEADBEEF, 2, 32'h0, 0);
        do_acc("rd_al",   0, 2'd2, 12'h010, 32'h0,        4, 32'hDEADBEEF, 0);

        // Byte RMW into lane 3
        do_acc("wr_base", 1, 2'd2, 12'h010, 32'h11223344, 2, 32'h0, 0);
        do_acc("wr_byte", 1, 2'd0, 12'h013, 32'hFFFFFFAB, 5, 32'h0, 0);
        do_acc("rd_w10",  0, 2'd2, 12'h010, 32'h0,        4, 32'hAB223344, 0);
        do_acc("rd_b13",  0, 2'd0, 12'h013, 32'h0,        4, 32'h000000AB, 0);

        // Spanning word write over zeros
        do_acc("clr10",   1, 2'd2, 12'h010, 32'h0,        2, 32'h0, 0);
        do_acc("clr14",   1, 2'd2, 12'h014, 32'h0,        2, 32'h0, 0);
        do_acc("wr_span", 1, 2'd2, 12'h012, 32'hCAFEBABE, 6, 32'h0, 0);
        do_acc("rd_s10",  0, 2'd2, 12'h010, 32'h0,        4, 32'hBABE0000, 0);
        do_acc("rd_s14",  0, 2'd2, 12'h014, 32'h0,        4, 32'h0000CAFE, 0);
        do_acc("rd_s12",  0, 2'd2, 12'h012, 32'h0,        4, 32'hCAFEBABE, 0);
        do_acc("rd_h11",  0, 2'd1, 12'h011, 32'h0,        4, 32'h0000BE00, 0);
        do_acc("rd_sz3",  0, 2'd3, 12'h010, 32'h0,        4, 32'hBABE0000, 0);

        // Half write straddling the top word into word 0
        do_acc("clrtop",  1, 2'd2, 12'hFFC, 32'h0,        2, 32'h0, 0);
        do_acc("clr00",   1, 2'd2, 12'h000, 32'h0,        2, 32'h0, 0);
        do_acc("wr_wrap", 1, 2'd1, 12'hFFF, 32'hFFFF1234, 6, 32'h0, 0);
        do_acc("rd_top",  0, 2'd2, 12'hFFC, 32'h0,        4, 32'h34000000, 0);
        do_acc("rd_w0",   0, 2'd2, 12'h000, 32'h0,        4, 32'h00000012, 0);
        do_acc("rd_wrap", 0, 2'd1, 12'hFFF, 32'h0,        4, 32'h00001234, 0);

        // req held high throughout a busy access
        do_acc("rd_hold", 0, 2'd2, 12'h010, 32'h0,        4, 32'hBABE0000, 1);
        repeat (4) @(negedge clk);
        check("hold_done_count", ndone, exp_dones);

        // Reset during WR1 of a spanning write
        do_acc("pre20",   1, 2'd2, 12'h020, 32'h11111111, 2, 32'h0, 0);
        do_acc("pre24",   1, 2'd2, 12'h024, 32'h22222222, 2, 32'h0, 0);
        do_acc("rd_pre",  0, 2'd2, 12'h024, 32'h0,        4, 32'h22222222, 0);
        do_acc("wr_rst",  1, 2'd2, 12'h022, 32'hCAFEBABE, 0, 32'h0, 0);
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_ready", {31'd0, ready}, 32'd1);
        check("midrst_done",  {31'd0, done},  32'd0);
        check("midrst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        do_acc("rd_r20",  0, 2'd2, 12'h020, 32'h0,        4, 32'hBABE1111, 0);
        do_acc("rd_r24",  0, 2'd2, 12'h024, 32'h0,        4, 32'h22222222, 0);

        repeat (5) @(negedge clk);
        check("sb_empty",    sb.size(), 32'd0);
        check("done_count",  ndone, exp_dones);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
